bitstream_fetch_ctrl: RTL and testbench
=======================================

Name: bitstream_fetch_ctrl

Overview:
- Sits between the 9-bit word source (bitstream file reader in simulation, memory fetch unit in silicon) and the arithmetic decoder's renormalisation/bypass logic.
- Sequences word fetches with a request/acknowledge handshake and holds fetched bits in an MSB-first bit buffer.
- Serves variable-length bit reads (1..MAX_RD bits) to the decoder, stalling it when the buffer is short.
- Tracks end-of-stream and flags underflow.

Parameters:
- WORD_W, 9, width of one source word.
- BUF_W, 32, bit-buffer capacity in bits.
- MAX_RD, 16, largest single read; must satisfy MAX_RD <= BUF_W-WORD_W+1.

Ports:
- clk  in  1  single clock, all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- src_req  out  1  one-cycle pulse requesting the next word.
- src_ack  in  1  one-cycle response to a request; carries src_data or src_eof.
- src_data  in  WORD_W  word, valid when src_ack && !src_eof.
- src_eof  in  1  with src_ack: no more data.
- rd_req  in  1  decoder read request.
- rd_num  in  $clog2(MAX_RD+1)  bits requested.
- rd_ready  out  1  read can be accepted this cycle (combinational).
- rd_valid  out  1  one-cycle pulse, result valid.
- rd_data  out  MAX_RD  result, right-aligned, zero above rd_num bits.
- rd_underflow  out  1  with rd_valid: result padded past end of stream.
- eos  out  1  sticky: src_eof seen and buffer empty.

Behaviour:
- Reset values:
  - Outputs: src_req=0, rd_valid=0, rd_data=0, rd_underflow=0, eos=0.
  - Internal: buffer=0, lvl=0, eof_seen=0, FSM=IDLE.
- Buffer and level:
  - Buffer is MSB-first: the oldest bit sits at buf[BUF_W-1].
  - lvl counts valid bits, range 0..BUF_W.
- FSM states IDLE, REQ, WAIT:
  - IDLE -> REQ when lvl <= BUF_W-WORD_W (using lvl after this cycle's consume) and !eof_seen.
  - REQ: src_req=1 for exactly one cycle, then -> WAIT.
  - WAIT: ignore everything until src_ack.
    - src_ack && !src_eof: append src_data at bits [BUF_W-1-lvl' -: WORD_W]; lvl += WORD_W; -> IDLE.
    - src_ack && src_eof: set eof_seen; -> IDLE; no further requests.
  - src_ack outside WAIT is ignored.
  - At most one request is ever outstanding.
- Read handshake:
  - rd_ready = (lvl >= rd_num) || eof_seen.
  - Transfer when rd_req && rd_ready.
  - The top rd_num bits are consumed in that cycle; rd_valid/rd_data are registered one cycle later (latency 1).
  - Back-to-back reads are allowed every cycle.
- Simultaneous consume and append in one cycle:
  - Shift out rd_num bits first, then append at the post-consume level.
  - lvl_next = lvl - rd_num + WORD_W; never exceeds BUF_W given the refill threshold.
- rd_num = 0: accepted immediately; rd_valid pulses with rd_data=0; no change to the buffer.
- Short read after eof (lvl < rd_num with eof_seen):
  - Return the lvl available bits in the MSBs of the result field, zero-filled LSBs.
  - rd_underflow=1; lvl -> 0.
- eos = eof_seen && lvl==0; it stays high until reset.
- Read before first fill: rd_ready stays low; the decoder stalls with no side effects.
- Reset mid-WAIT: state returns to IDLE; a late src_ack is ignored; a fresh src_req is issued on the first cycle after rst falls.
- rd_num > MAX_RD is illegal; a simulation assertion flags it.

Optional Feature:
- Macro: BITSTREAM_FETCH_STATS_EN.
- Defined: adds outputs stat_bits [31:0] (total bits consumed, saturating) and stat_words [15:0] (words appended, wrapping). Both are cleared by rst and update in the cycle of the event.
- Undefined: these ports and counters do not exist; all other behaviour is identical.

Decomposition:
- Package vvc_bs_pkg holds:
  - WORD_W default.
  - fetch FSM enum (IDLE/REQ/WAIT).
  - level-width constant function.
  - rd_num width localparam helper.
- One sub-module, bs_bit_buffer: buffer register plus lvl, with combined consume/append ports. The FSM and handshake stay in the top level.

Test Plan:
- Reset, then source answers each src_req after 3 cycles with 9'h1FF, 9'h000, 9'h155, 9'h0AA. Read 9 -> rd_data=9'h1FF. Read 4 -> 0. Read 5 -> 0. Read 9 -> 9'h155. Each rd_valid arrives 1 cycle after acceptance.
- Source slowed to a 20-cycle ack latency while the decoder reads 16 bits every cycle: rd_ready drops, no data lost or duplicated, src_req never pulses twice before src_ack.
- Single word 9'h1A5 then eof. Read 12 -> rd_data=12'h1A5<<3 (0xD28), rd_underflow=1, eos=1 the next cycle, no further src_req.
- Consume and append in the same cycle at lvl=23 with rd_num=7 -> lvl=25, bit order preserved against a golden bit-queue model.
- Assert rst during WAIT, then deliver a stale src_ack -> ignored; lvl=0; new src_req on the first post-reset cycle.
- rd_num=0 request -> rd_valid with 0, lvl unchanged. With BITSTREAM_FETCH_STATS_EN defined, stat_bits and stat_words match the model after a 1000-read random run.

Source files
------------

// File: rtl/vvc_bs_pkg.sv
// vvc_bs_pkg: shared types and width helpers for the bitstream fetch slice.
package vvc_bs_pkg;

    localparam int WORD_W_DEF = 9;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        WAIT = 2'd2
    } fetch_state_e;

    function automatic int lvl_width(input int buf_w);
        return $clog2(buf_w + 1);
    endfunction

    function automatic int num_width(input int max_rd);
        return $clog2(max_rd + 1);
    endfunction

endpackage

// File: rtl/bs_bit_buffer.sv
// bs_bit_buffer: MSB-first bit buffer with fill level.
// Consume shifts out the oldest bits, append lands after the survivors.
module bs_bit_buffer
    import vvc_bs_pkg::*;
#(
    parameter int  WORD_W = WORD_W_DEF,
    parameter int  BUF_W  = 32,
    parameter int  MAX_RD = 16,
    localparam int LW     = lvl_width(BUF_W),
    localparam int NW     = num_width(MAX_RD)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              cons_en,
    input  logic [NW-1:0]     cons_num,
    input  logic              app_en,
    input  logic [WORD_W-1:0] app_data,
    output logic [LW-1:0]     lvl,
    output logic [LW-1:0]     lvl_post,
    output logic [MAX_RD-1:0] peek
);

    logic [BUF_W-1:0] bits_q;
    logic [BUF_W-1:0] shifted;
    logic [BUF_W-1:0] placed;
    logic [BUF_W-1:0] bits_d;
    logic [LW-1:0]    num_ext;
    logic [LW-1:0]    taken;
    logic [LW-1:0]    lvl_d;

    assign num_ext  = LW'(cons_num);
    assign taken    = !cons_en      ? '0  :
                      (num_ext > lvl) ? lvl : num_ext;
    assign lvl_post = lvl - taken;

    // Bits below lvl are always zero, so a short read pads itself.
    assign peek = MAX_RD'(bits_q >> (BUF_W - int'(cons_num)));

    assign shifted = cons_en ? (bits_q << cons_num) : bits_q;
    assign placed  = {app_data, {(BUF_W-WORD_W){1'b0}}} >> lvl_post;
    assign bits_d  = app_en ? (shifted | placed) : shifted;
    assign lvl_d   = app_en ? (lvl_post + LW'(WORD_W)) : lvl_post;

    always_ff @(posedge clk) begin
        if (rst) begin
            bits_q <= '0;
            lvl    <= '0;
        end else begin
            bits_q <= bits_d;
            lvl    <= lvl_d;
        end
    end

endmodule

// File: rtl/bitstream_fetch_ctrl.sv
// bitstream_fetch_ctrl: word fetch sequencer and variable-length bit reader.
// Usage counters are built when BITSTREAM_FETCH_STATS_EN is defined.
module bitstream_fetch_ctrl
    import vvc_bs_pkg::*;
#(
    parameter int  WORD_W = WORD_W_DEF,
    parameter int  BUF_W  = 32,
    parameter int  MAX_RD = 16,
    localparam int NW     = num_width(MAX_RD)
) (
    input  logic              clk,
    input  logic              rst,
    output logic              src_req,
    input  logic              src_ack,
    input  logic [WORD_W-1:0] src_data,
    input  logic              src_eof,
    input  logic              rd_req,
    input  logic [NW-1:0]     rd_num,
    output logic              rd_ready,
    output logic              rd_valid,
    output logic [MAX_RD-1:0] rd_data,
    output logic              rd_underflow,
`ifdef BITSTREAM_FETCH_STATS_EN
    output logic [31:0]       stat_bits,
    output logic [15:0]       stat_words,
`endif
    output logic              eos
);

    localparam int LW = lvl_width(BUF_W);
    localparam logic [LW-1:0] REFILL_AT = LW'(BUF_W - WORD_W);

    fetch_state_e      state_q;
    fetch_state_e      state_d;
    logic              eof_seen;
    logic              short_rd;
    logic              xfer;
    logic              ack_data;
    logic              ack_eof;
    logic [LW-1:0]     lvl;
    logic [LW-1:0]     lvl_post;
    logic [MAX_RD-1:0] peek;

    assign short_rd = LW'(rd_num) > lvl;
    assign rd_ready = !short_rd || eof_seen;
    assign xfer     = rd_req && rd_ready;
    assign ack_data = (state_q == WAIT) && src_ack && !src_eof;
    assign ack_eof  = (state_q == WAIT) && src_ack && src_eof;
    assign eos      = eof_seen && (lvl == '0);

    bs_bit_buffer #(
        .WORD_W (WORD_W),
        .BUF_W  (BUF_W),
        .MAX_RD (MAX_RD)
    ) u_buf (
        .clk      (clk),
        .rst      (rst),
        .cons_en  (xfer),
        .cons_num (rd_num),
        .app_en   (ack_data),
        .app_data (src_data),
        .lvl      (lvl),
        .lvl_post (lvl_post),
        .peek     (peek)
    );

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    // Refill decision looks at the level left after this cycle's read.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (!eof_seen && lvl_post <= REFILL_AT)
                    state_d = REQ;
            end
            REQ:  state_d = WAIT;
            WAIT: begin
                if (src_ack) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        src_req = (state_q == REQ);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            eof_seen     <= 1'b0;
            rd_valid     <= 1'b0;
            rd_data      <= '0;
            rd_underflow <= 1'b0;
        end else begin
            if (ack_eof) eof_seen <= 1'b1;
            rd_valid     <= xfer;
            rd_underflow <= xfer && eof_seen && short_rd;
            if (xfer) rd_data <= peek;
        end
    end

`ifdef BITSTREAM_FETCH_STATS_EN
    logic [LW-1:0] taken;
    logic [32:0]   bits_sum;

    assign taken    = lvl - lvl_post;
    assign bits_sum = {1'b0, stat_bits} + 33'(taken);

    always_ff @(posedge clk) begin
        if (rst) begin
            stat_bits  <= '0;
            stat_words <= '0;
        end else begin
            stat_bits <= bits_sum[32] ? '1 : bits_sum[31:0];
            if (ack_data) stat_words <= stat_words + 16'd1;
        end
    end
`endif

    // A request wider than the result field cannot be represented.
    assert property (@(posedge clk) disable iff (rst)
        rd_req |-> (rd_num <= NW'(MAX_RD)));

endmodule

// File: tb/tb_bitstream_fetch_ctrl.sv
// tb_bitstream_fetch_ctrl: scoreboard bench for the bitstream fetch controller.
// Define BITSTREAM_FETCH_STATS_EN to also check the usage counters.
module tb_bitstream_fetch_ctrl;

    localparam int WORD_W = 9;
    localparam int BUF_W  = 32;
    localparam int MAX_RD = 16;
    localparam int NW     = 5;

    typedef struct {
        logic [MAX_RD-1:0] data;
        logic              uf;
        int                due;
    } exp_t;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              src_req;
    logic              src_ack = 1'b0;
    logic [WORD_W-1:0] src_data = '0;
    logic              src_eof = 1'b0;
    logic              rd_req = 1'b0;
    logic [NW-1:0]     rd_num = '0;
    logic              rd_ready;
    logic              rd_valid;
    logic [MAX_RD-1:0] rd_data;
    logic              rd_underflow;
    logic              eos;
`ifdef BITSTREAM_FETCH_STATS_EN
    logic [31:0]       stat_bits;
    logic [15:0]       stat_words;
`endif

    int checks = 0;
    int errors = 0;
    int negcnt = 0;
    int lat = 3;
    int cnt = 0;
    int stalls = 0;
    int acked_words = 0;
    longint bits_model = 0;

    bit auto_on = 1'b0;
    bit eof_on = 1'b0;
    bit pend = 1'b0;
    bit man_fire = 1'b0;
    bit man_eof = 1'b0;
    bit man_stale = 1'b0;
    logic [WORD_W-1:0] man_data = '0;

    bit                gq[$];
    exp_t              sb[$];
    logic [WORD_W-1:0] words[$];

    bitstream_fetch_ctrl #(
        .WORD_W (WORD_W),
        .BUF_W  (BUF_W),
        .MAX_RD (MAX_RD)
    ) dut (
        .clk          (clk),
        .rst          (rst),
        .src_req      (src_req),
        .src_ack      (src_ack),
        .src_data     (src_data),
        .src_eof      (src_eof),
        .rd_req       (rd_req),
        .rd_num       (rd_num),
        .rd_ready     (rd_ready),
        .rd_valid     (rd_valid),
        .rd_data      (rd_data),
        .rd_underflow (rd_underflow),
`ifdef BITSTREAM_FETCH_STATS_EN
        .stat_bits    (stat_bits),
        .stat_words   (stat_words),
`endif
        .eos          (eos)
    );

    always #5 clk = ~clk;

    function automatic void push_word(input logic [WORD_W-1:0] w);
        for (int i = WORD_W - 1; i >= 0; i--) gq.push_back(w[i]);
    endfunction

    // Scoreboard checker and source responder, both away from the active edge.
    always @(negedge clk) begin
        exp_t e;
        logic [WORD_W-1:0] w;
        negcnt++;
        if (sb.size() > 0 && sb[0].due == negcnt) begin
            e = sb.pop_front();
            checks++;
            if (rd_valid !== 1'b1 || rd_data !== e.data ||
                rd_underflow !== e.uf) begin
                errors++;
                $display("FAIL rd_result: valid=%b data=%h uf=%b, want valid=1 data=%h uf=%b",
                         rd_valid, rd_data, rd_underflow, e.data, e.uf);
            end
        end else if (rd_valid === 1'b1) begin
            checks++;
            errors++;
            $display("FAIL rd_valid_spurious: got 1 want 0 (data=%h)", rd_data);
        end
        src_ack = 1'b0;
        src_eof = 1'b0;
        if (man_fire) begin
            src_ack  = 1'b1;
            src_data = man_data;
            src_eof  = man_eof;
            man_fire = 1'b0;
            if (!man_stale) begin
                pend = 1'b0;
                if (!man_eof) begin
                    push_word(man_data);
                    acked_words++;
                end
            end
        end
        if (rst) begin
            pend = 1'b0;
        end else begin
            if (auto_on && pend && !src_ack) begin
                if (cnt > 1) begin
                    cnt--;
                end else if (words.size() > 0) begin
                    w = words.pop_front();
                    src_ack = 1'b1;
                    src_data = w;
                    push_word(w);
                    acked_words++;
                    pend = 1'b0;
                end else if (eof_on) begin
                    src_ack = 1'b1;
                    src_eof = 1'b1;
                    pend = 1'b0;
                end
            end
            if (src_req === 1'b1) begin
                checks++;
                if (pend) begin
                    errors++;
                    $display("FAIL src_req_outstanding: got second src_req want none before src_ack");
                end
                pend = 1'b1;
                cnt = lat;
            end
        end
    end

    task automatic apply_reset();
        rst = 1'b1;
        rd_req = 1'b0;
        rd_num = '0;
        auto_on = 1'b0;
        eof_on = 1'b0;
        man_fire = 1'b0;
        man_stale = 1'b0;
        lat = 3;
        gq.delete();
        sb.delete();
        words.delete();
        acked_words = 0;
        bits_model = 0;
        repeat (3) @(negedge clk);
        #1;
        rst = 1'b0;
    endtask

    // Called just after a falling edge; returns just after the next one.
    task automatic do_read(input int n);
        int w;
        int sz;
        exp_t e;
        logic [MAX_RD-1:0] d;
        bit b;
        rd_req = 1'b1;
        rd_num = NW'(n);
        #1;
        w = 0;
        while (rd_ready !== 1'b1 && w < 300) begin
            @(negedge clk);
            #1;
            w++;
            stalls++;
        end
        if (rd_ready !== 1'b1) begin
            checks++;
            errors++;
            $display("FAIL rd_ready_timeout: rd_ready=%b want 1 for rd_num=%0d", rd_ready, n);
            rd_req = 1'b0;
            return;
        end
        sz = gq.size();
        e.uf = (sz < n);
        bits_model += (sz < n) ? sz : n;
        d = '0;
        for (int i = 0; i < n; i++) begin
            b = (gq.size() > 0) ? gq.pop_front() : 1'b0;
            d = {d[MAX_RD-2:0], b};
        end
        e.data = d;
        e.due = negcnt + 1;
        sb.push_back(e);
        @(negedge clk);
        #1;
        rd_req = 1'b0;
    endtask

    task automatic wait_req(input string tag);
        int w = 0;
        while (src_req !== 1'b1 && w < 100) begin
            @(negedge clk);
            #1;
            w++;
        end
        checks++;
        if (src_req !== 1'b1) begin
            errors++;
            $display("FAIL %s: src_req=%b want 1", tag, src_req);
        end
    endtask

    task automatic fire(input logic [WORD_W-1:0] d, input bit eof);
        man_data = d;
        man_eof = eof;
        man_stale = 1'b0;
        man_fire = 1'b1;
        @(negedge clk);
        #1;
    endtask

    task automatic drain(input string tag);
        int w = 0;
        while (sb.size() > 0 && w < 20) begin
            @(negedge clk);
            #1;
            w++;
        end
        checks++;
        if (sb.size() > 0) begin
            errors++;
            $display("FAIL %s_drain: %0d results outstanding want 0", tag, sb.size());
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (src_req !== 1'b0) begin
            errors++;
            $display("FAIL reset_src_req: got %b want 0", src_req);
        end
        checks++;
        if (rd_valid !== 1'b0) begin
            errors++;
            $display("FAIL reset_rd_valid: got %b want 0", rd_valid);
        end
        checks++;
        if (rd_data !== '0) begin
            errors++;
            $display("FAIL reset_rd_data: got %h want 0", rd_data);
        end
        checks++;
        if (rd_underflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_rd_underflow: got %b want 0", rd_underflow);
        end
        checks++;
        if (eos !== 1'b0) begin
            errors++;
            $display("FAIL reset_eos: got %b want 0", eos);
        end
        rst = 1'b0;
        rd_req = 1'b1;
        rd_num = NW'(1);
        repeat (6) begin
            @(negedge clk);
            #1;
            checks++;
            if (rd_ready !== 1'b0) begin
                errors++;
                $display("FAIL empty_rd_ready: got %b want 0", rd_ready);
            end
        end
        rd_req = 1'b0;
    endtask

    task automatic test_basic();
        apply_reset();
        words = '{9'h1FF, 9'h000, 9'h155, 9'h0AA};
        auto_on = 1'b1;
        do_read(9);
        do_read(4);
        do_read(5);
        do_read(9);
        drain("basic");
    endtask

    task automatic test_slow_source();
        apply_reset();
        lat = 20;
        for (int i = 0; i < 40; i++) words.push_back(WORD_W'($urandom));
        auto_on = 1'b1;
        stalls = 0;
        for (int i = 0; i < 20; i++) do_read(16);
        drain("slow");
        checks++;
        if (stalls == 0) begin
            errors++;
            $display("FAIL slow_stall: rd_ready never low, stalls=%0d want >0", stalls);
        end
    endtask

    task automatic test_eof();
        int reqs = 0;
        apply_reset();
        words = '{9'h1A5};
        eof_on = 1'b1;
        auto_on = 1'b1;
        checks++;
        if (eos !== 1'b0) begin
            errors++;
            $display("FAIL eof_eos_early: got %b want 0", eos);
        end
        do_read(12);
        checks++;
        if (eos !== 1'b1) begin
            errors++;
            $display("FAIL eof_eos: got %b want 1", eos);
        end
        repeat (30) begin
            @(negedge clk);
            #1;
            if (src_req === 1'b1) reqs++;
        end
        checks++;
        if (reqs != 0) begin
            errors++;
            $display("FAIL eof_no_req: got %0d src_req pulses want 0", reqs);
        end
        do_read(5);
        drain("eof");
    endtask

    task automatic test_overlap();
        apply_reset();
        for (int i = 0; i < 3; i++) begin
            wait_req("overlap_fill_req");
            fire(WORD_W'($urandom), 1'b0);
        end
        do_read(4);
        wait_req("overlap_refill_req");
        man_data = 9'h13B;
        man_eof = 1'b0;
        man_stale = 1'b0;
        man_fire = 1'b1;
        @(negedge clk);
        #1;
        do_read(7);
        checks++;
        if (dut.u_buf.lvl !== 6'd25) begin
            errors++;
            $display("FAIL overlap_lvl: got %0d want 25", dut.u_buf.lvl);
        end
        do_read(16);
        do_read(9);
        drain("overlap");
    endtask

    task automatic test_stale_reset();
        apply_reset();
        wait_req("stale_first_req");
        @(negedge clk);
        #1;
        rst = 1'b1;
        repeat (2) @(negedge clk);
        #1;
        rst = 1'b0;
        man_data = 9'h0C7;
        man_eof = 1'b0;
        man_stale = 1'b1;
        man_fire = 1'b1;
        @(negedge clk);
        #1;
        man_stale = 1'b0;
        checks++;
        if (src_req !== 1'b1) begin
            errors++;
            $display("FAIL stale_post_reset_req: got %b want 1", src_req);
        end
        repeat (3) @(negedge clk);
        #1;
        checks++;
        if (dut.u_buf.lvl !== 6'd0) begin
            errors++;
            $display("FAIL stale_lvl: got %0d want 0", dut.u_buf.lvl);
        end
        fire(9'h0F3, 1'b0);
        do_read(9);
        drain("stale");
    endtask

    task automatic test_zero_read();
        apply_reset();
        do_read(0);
        wait_req("zero_req");
        fire(9'h1C3, 1'b0);
        do_read(3);
        checks++;
        if (dut.u_buf.lvl !== 6'd6) begin
            errors++;
            $display("FAIL zero_pre_lvl: got %0d want 6", dut.u_buf.lvl);
        end
        do_read(0);
        checks++;
        if (dut.u_buf.lvl !== 6'd6) begin
            errors++;
            $display("FAIL zero_lvl: got %0d want 6", dut.u_buf.lvl);
        end
        do_read(6);
        drain("zero");
    endtask

    task automatic test_random();
        apply_reset();
        lat = 1;
        for (int i = 0; i < 1200; i++) words.push_back(WORD_W'($urandom));
        auto_on = 1'b1;
        for (int i = 0; i < 1000; i++) do_read(int'($urandom_range(0, MAX_RD)));
        drain("random");
        auto_on = 1'b0;
        repeat (4) @(negedge clk);
        #1;
`ifdef BITSTREAM_FETCH_STATS_EN
        checks++;
        if (stat_bits !== bits_model[31:0]) begin
            errors++;
            $display("FAIL stat_bits: got %0d want %0d", stat_bits, bits_model);
        end
        checks++;
        if (stat_words !== acked_words[15:0]) begin
            errors++;
            $display("FAIL stat_words: got %0d want %0d", stat_words, acked_words);
        end
`endif
    endtask

    initial begin
        test_reset();
        test_basic();
        test_slow_source();
        test_eof();
        test_overlap();
        test_stale_reset();
        test_zero_read();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #600000;
        errors++;
        $display("FAIL timeout: simulation still running at %0t want finished", $time);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $fatal(1, "timeout");
    end

endmodule
